// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: line-activity FSM, deferred receiver configuration,
// receive FIFO with parity tag, and sticky overrun / framing / character-timeout status.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic                          rx_clk,
  input  logic                          rst,
  input  logic                          rx_tick,
  input  logic                          rx,
  input  logic                          rx_done,
  input  logic                          rx_framing_error,
  input  logic                          rx_parity_error,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  input  logic                          cfg_wr,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_odd_r_even,
  output logic                          parity_en,
  output logic                          odd_r_even_parity,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_perr,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          timeout,
  input  logic                          clr_status
);

  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = AW + 1;
  localparam int GUARD_MAX = 16 * (DATA_WIDTH + 3) - 1;
  localparam int GW        = $clog2(GUARD_MAX + 1);
  localparam int TW        = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [GW-1:0] GUARD_LIM = GW'(GUARD_MAX);
  localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT_TICKS);
  localparam logic [TW-1:0] TO_PRE    = TW'(TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {LINE_IDLE = 1'b0, FRAME = 1'b1} line_state_t;

  line_state_t         state_r, state_next_s;
  logic [GW-1:0]       guard_r;
  logic                pend_r, pend_pe_r, pend_odd_r;
  logic [DATA_WIDTH:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]       count_r;
  logic [TW-1:0]       to_cnt_r;
  logic                fe_d_r;
  logic                full_s, empty_s, push_s, pop_s;
  logic                ovr_set_s, fe_set_s, to_set_s, to_clr_s, to_inc_s;

  assign full_s    = (count_r == FULL_CNT);
  assign empty_s   = (count_r == {CW{1'b0}});
  assign pop_s     = m_ready && !empty_s;
  assign push_s    = rx_done && !rx_framing_error && (!full_s || pop_s);
  assign ovr_set_s = rx_done && !rx_framing_error && full_s && !pop_s;
  assign fe_set_s  = rx_framing_error && !fe_d_r;
  assign to_clr_s  = push_s || pop_s || empty_s;
  assign to_inc_s  = !to_clr_s && (state_r == LINE_IDLE) && rx_tick && (to_cnt_r != TO_LIM);
  assign to_set_s  = to_inc_s && (to_cnt_r == TO_PRE);

  assign m_valid    = !empty_s;
  assign m_data     = mem_r[rd_ptr_r][DATA_WIDTH-1:0];
  assign m_perr     = mem_r[rd_ptr_r][DATA_WIDTH];
  assign fifo_count = count_r;

  // Line state register
  always_ff @(posedge rx_clk) begin
    if (rst) state_r <= LINE_IDLE;
    else     state_r <= state_next_s;
  end

  // Line next-state: moves only on rx_tick cycles
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      LINE_IDLE: begin
        if (rx_tick && !rx) state_next_s = FRAME;
        else                state_next_s = LINE_IDLE;
      end
      FRAME: begin
        if (rx_tick && (rx_done || (rx && guard_r == GUARD_LIM))) state_next_s = LINE_IDLE;
        else                                                     state_next_s = FRAME;
      end
      default: state_next_s = LINE_IDLE;
    endcase
  end

  // Guard counter held at zero while idle so every frame starts from zero
  always_ff @(posedge rx_clk) begin
    if (rst)                                guard_r <= '0;
    else if (state_r == LINE_IDLE)          guard_r <= '0;
    else if (rx_tick && guard_r != GUARD_LIM) guard_r <= guard_r + {{(GW-1){1'b0}}, 1'b1};
    else                                    guard_r <= guard_r;
  end

  // Configuration is staged and only applied between frames; a new write overrides the transfer
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      pend_r            <= 1'b0;
      pend_pe_r         <= 1'b0;
      pend_odd_r        <= 1'b0;
      parity_en         <= 1'b0;
      odd_r_even_parity <= 1'b0;
    end else begin
      if (pend_r && state_r == LINE_IDLE) begin
        parity_en         <= pend_pe_r;
        odd_r_even_parity <= pend_odd_r;
        pend_r            <= 1'b0;
      end else begin
        parity_en         <= parity_en;
        odd_r_even_parity <= odd_r_even_parity;
      end
      if (cfg_wr) begin
        pend_r     <= 1'b1;
        pend_pe_r  <= cfg_parity_en;
        pend_odd_r <= cfg_odd_r_even;
      end else begin
        pend_pe_r  <= pend_pe_r;
        pend_odd_r <= pend_odd_r;
      end
    end
  end

  // Receive FIFO storage, pointers and occupancy
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {rx_parity_error, rx_data};
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      else       rd_ptr_r <= rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Character timeout counter and sticky status; a set event beats clr_status
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      to_cnt_r  <= '0;
      fe_d_r    <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if (to_clr_s)      to_cnt_r <= '0;
      else if (to_inc_s) to_cnt_r <= to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
      else               to_cnt_r <= to_cnt_r;
      fe_d_r    <= rx_framing_error;
      overrun   <= (overrun   && !clr_status) || ovr_set_s;
      frame_err <= (frame_err && !clr_status) || fe_set_s;
      timeout   <= (timeout   && !clr_status) || to_set_s;
    end
  end

endmodule
